// File: rtl/aud_player_i2s.sv
// Serialises PCM samples onto the WM8731 DACDAT pin, framed by DACLRCK.
// I2S or left-justified; one ack per stereo frame on the left edge.
module aud_player_i2s #(
  parameter int DATA_W    = 16,
  parameter bit I2S_DELAY = 1'b1,
  parameter bit MONO      = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_sample_ack,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } state_t;

  state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lrck_q, lrck_d;
  logic primed_q, primed_d;
  logic active_q, active_d;
  logic dacdat_q, dacdat_d;
  logic ack_q, ack_d;

  logic edge_s;
  logic left_s;
  logic right_s;
  logic load;
  logic [DATA_W-1:0] word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      sample_q <= '0;
      cnt_q    <= '0;
      lrck_q   <= 1'b0;
      primed_q <= 1'b0;
      active_q <= 1'b0;
      dacdat_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      lrck_q   <= lrck_d;
      primed_q <= primed_d;
      active_q <= active_d;
      dacdat_q <= dacdat_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    lrck_d   = i_daclrck;
    primed_d = 1'b1;
    dacdat_d = 1'b0;
    ack_d    = 1'b0;
    load     = 1'b0;
    word     = '0;

    edge_s  = primed_q && (i_daclrck != lrck_q);
    left_s  = edge_s && !i_daclrck;
    right_s = edge_s && i_daclrck;

    if (!i_en) begin
      state_d  = IDLE;
      active_d = 1'b0;
    end else if (left_s) begin
      sample_d = i_dac_data;
      word     = i_dac_data;
      load     = 1'b1;
      ack_d    = 1'b1;
      active_d = 1'b1;
    end else if (right_s && active_q) begin
      word = MONO ? sample_q : '0;
      load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, PAD: ;
        DELAY: begin
          dacdat_d = shift_q[DATA_W-1];
          shift_d  = shift_q << 1;
          cnt_d    = CW'(DATA_W - 1);
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_d = PAD;
          end else begin
            dacdat_d = shift_q[DATA_W-1];
            shift_d  = shift_q << 1;
            cnt_d    = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // An edge always restarts the word, abandoning any bits still queued.
    if (load) begin
      if (I2S_DELAY) begin
        state_d = DELAY;
        shift_d = word;
      end else begin
        state_d  = SHIFT;
        dacdat_d = word[DATA_W-1];
        shift_d  = word << 1;
        cnt_d    = CW'(DATA_W - 1);
      end
    end
  end

  assign o_aud_dacdat = dacdat_q;
  assign o_sample_ack = ack_q;
  assign o_busy       = (state_q == DELAY) || (state_q == SHIFT);

endmodule

// File: tb/tb_aud_player_i2s.sv
// Randomised bench for aud_player_i2s against a frame-level model.
// Two instances: I2S+mono and left-justified+zero-right.
module tb_aud_player_i2s;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic lrck;
  logic [W-1:0] data;
  logic dac [2];
  logic ack [2];
  logic busy [2];

  always #5 clk = ~clk;

  aud_player_i2s #(.DATA_W(W), .I2S_DELAY(1'b1), .MONO(1'b1)) u_i2s (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_daclrck    (lrck),
    .i_dac_data   (data),
    .o_aud_dacdat (dac[0]),
    .o_sample_ack (ack[0]),
    .o_busy       (busy[0])
  );

  aud_player_i2s #(.DATA_W(W), .I2S_DELAY(1'b0), .MONO(1'b0)) u_lj (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_daclrck    (lrck),
    .i_dac_data   (data),
    .o_aud_dacdat (dac[1]),
    .o_sample_ack (ack[1]),
    .o_busy       (busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // frame-level reference: a frame is (word, start cycle); bits are indexed from it
  bit m_primed, m_prev, m_active, m_valid, m_ack;
  logic [W-1:0] m_sample;
  logic [W-1:0] m_word [2];
  int m_start;
  int dly [2] = '{1, 0};
  bit mono [2] = '{1'b1, 1'b0};

  int ph = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed = 0;
    m_prev   = 0;
    m_active = 0;
    m_valid  = 0;
    m_ack    = 0;
    m_sample = '0;
  endtask

  task automatic model_step();
    bit e;
    e = m_primed && (lrck != m_prev);
    m_prev   = lrck;
    m_primed = 1;
    m_ack    = 0;
    if (!en) begin
      m_active = 0;
      m_valid  = 0;
    end else if (e && !lrck) begin
      m_sample = data;
      m_word[0] = data;
      m_word[1] = data;
      m_start  = cyc;
      m_valid  = 1;
      m_ack    = 1;
      m_active = 1;
    end else if (e && lrck && m_active) begin
      for (int i = 0; i < 2; i++)
        m_word[i] = mono[i] ? m_sample : '0;
      m_start = cyc;
      m_valid = 1;
    end
  endtask

  function automatic logic exp_dac(int i);
    int k;
    k = cyc - m_start - dly[i];
    if (!m_valid || k < 0 || k >= W) return 1'b0;
    return m_word[i][W-1-k];
  endfunction

  function automatic logic exp_busy(int i);
    return m_valid && (cyc - m_start) < (W + dly[i]);
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dac%0d", i), 32'(dac[i]), 32'(exp_dac(i)));
      check($sformatf("ack%0d", i), 32'(ack[i]), 32'(m_ack));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(exp_busy(i)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  // hp = LRCK half period; en_rnd toggles enable; d_rnd randomises samples
  task automatic run(input int n, input int hp, input bit en_rnd,
                     input bit d_rnd);
    for (int c = 0; c < n; c++) begin
      if (ph >= hp) begin
        lrck = ~lrck;
        ph = 0;
      end
      ph++;
      if (en_rnd && $urandom_range(0, 39) == 0) en = ~en;
      if (d_rnd) data = W'($urandom);
      tick();
    end
  endtask

  initial begin
    int hps [4] = '{32, 10, 17, 20};
    bit got;
    rst_n = 1'b0;
    en    = 1'b0;
    lrck  = 1'b0;
    data  = '0;
    model_reset();
    #1;
    compare_all();
    repeat (3) tick();
    rst_n = 1'b1;

    en   = 1'b1;
    data = 16'hA5C3;
    run(200, 32, 1'b0, 1'b0);
    data = 16'h8001;
    run(200, 32, 1'b0, 1'b0);
    run(120, 10, 1'b0, 1'b0);

    en = 1'b0;
    run(40, 32, 1'b0, 1'b1);
    en = 1'b1;
    run(150, 32, 1'b0, 1'b1);

    for (int s = 0; s < 12; s++)
      run(200, hps[$urandom_range(0, 3)], 1'b1, 1'b1);

    en = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      run(1, 32, 1'b0, 1'b0);
      got = exp_busy(0) && (cyc - m_start) > 4;
    end
    check("reach_shift", 32'(got), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    lrck = 1'b1;
    ph = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    data = 16'h5A3C;
    run(300, 32, 1'b0, 1'b0);
    run(400, 20, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
